// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage, registered carry between stages.
// Optional ADDSUB_SATURATE_EN clamps the result to the signed limit on overflow.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             o
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    // Handshake: a transfer happens on valid && ready; the whole pipeline advances
    // together when the output slot is empty or being drained, otherwise everything holds.
    logic             adv;

    logic             v_q  [STAGES];
    logic             v_d  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] bx_q [STAGES];
    logic [WIDTH-1:0] bx_d [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             cy_q [STAGES];
    logic             cy_d [STAGES];
    logic             cm_q [STAGES];
    logic             cm_d [STAGES];

    // Inputs seen by each stage: stage 0 reads the ports, later stages read their predecessor.
    logic [WIDTH-1:0] pa  [STAGES];
    logic [WIDTH-1:0] pbx [STAGES];
    logic [WIDTH-1:0] ps  [STAGES];
    logic             pc  [STAGES];
    logic             pv  [STAGES];

    always_comb begin
        adv    = !v_q[LAST] || out_ready;
        pa[0]  = a;
        pbx[0] = b ^ {WIDTH{m}};
        ps[0]  = '0;
        pc[0]  = m;
        pv[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            pa[k]  = a_q[k-1];
            pbx[k] = bx_q[k-1];
            ps[k]  = s_q[k-1];
            pc[k]  = cy_q[k-1];
            pv[k]  = v_q[k-1];
        end
    end

    always_comb begin : slice_logic
        logic             carry;
        logic [WIDTH-1:0] sum;
        for (int k = 0; k < STAGES; k++) begin
            carry   = pc[k];
            sum     = ps[k];
            cm_d[k] = 1'b0;
            for (int i = 0; i < CHUNK; i++) begin
                // cm captures the carry entering the top bit, used for signed overflow.
                if (i == CHUNK - 1) cm_d[k] = carry;
                sum[k*CHUNK+i] = pa[k][k*CHUNK+i] ^ pbx[k][k*CHUNK+i] ^ carry;
                carry = (pa[k][k*CHUNK+i] & pbx[k][k*CHUNK+i])
                      | (carry & (pa[k][k*CHUNK+i] ^ pbx[k][k*CHUNK+i]));
            end
            a_d[k]  = pa[k];
            bx_d[k] = pbx[k];
            s_d[k]  = sum;
            cy_d[k] = carry;
            v_d[k]  = pv[k];
        end
`ifdef ADDSUB_SATURATE_EN
        if (cm_d[LAST] ^ cy_d[LAST]) begin
            s_d[LAST] = pa[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Data only loads behind a valid transaction, so the output keeps its last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
                cy_q[k] <= 1'b0;
                cm_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                if (v_d[k]) begin
                    a_q[k]  <= a_d[k];
                    bx_q[k] <= bx_d[k];
                    s_q[k]  <= s_d[k];
                    cy_q[k] <= cy_d[k];
                    cm_q[k] <= cm_d[k];
                end
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign c         = cy_q[LAST];
    assign o         = cm_q[LAST] ^ cy_q[LAST];
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, CHUNK=4): directed corner cases,
// streaming, backpressure, mid-stream reset and a randomized run against an arithmetic model.
module tb_addsub_pipe;
  localparam int W = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c;
  logic         o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit rand_done = 0;

  logic [W+1:0] exp_q[$];
  int           acc_cyc_q[$];
  int           acc_stall_q[$];

  logic         hold_valid = 1'b0;
  logic [W-1:0] held_s;
  logic         held_c;
  logic         held_o;

  addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c(c), .o(o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic; {c, o, s}
  function automatic logic [W+1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic mm);
    int          sa, sb, exact;
    int unsigned ua, ub, tot;
    logic [W-1:0] r;
    logic        cy, ov;
    sa = $signed(aa);
    sb = $signed(bb);
    ua = aa;
    ub = bb;
    exact = mm ? sa - sb : sa + sb;
    ov = (exact > 32767) || (exact < -32768);
    if (mm) begin
      tot = ua - ub;
      cy  = (ua >= ub);
    end else begin
      tot = ua + ub;
      cy  = (tot > 32'hFFFF);
    end
    r = tot[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (ov) r = (exact > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {cy, ov, r};
  endfunction

  // scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      acc_stall_q.delete();
      hold_valid = 1'b0;
    end else begin
      logic [W+1:0] e;
      if (hold_valid) begin
        check("hold_s", s, held_s);
        check("hold_c", c, held_c);
        check("hold_o", o, held_o);
      end
      check("in_ready", in_ready, (!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("s", s, e[W-1:0]);
          check("c", c, e[W+1]);
          check("o", o, e[W]);
          check("latency", cyc - acc_cyc_q.pop_front(), LAT + (stall_cnt - acc_stall_q.pop_front()));
        end
      end
      hold_valid = out_valid && !out_ready;
      if (hold_valid) stall_cnt++;
      held_s = s;
      held_c = c;
      held_o = o;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, m));
        acc_cyc_q.push_back(cyc);
        acc_stall_q.push_back(stall_cnt);
      end
    end
  end

  // driver tasks: entered and left #1 after a rising edge
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic mm);
    int guard = 0;
    in_valid = 1'b1;
    a = aa;
    b = bb;
    m = mm;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h4321;
    m = 1'b0;
    out_ready = 1'b1;
    // reset held two cycles with in_valid high
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_s", s, 16'h0000);
    check("rst_c", c, 1'b0);
    check("rst_o", o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    idle(6);

    // directed add/sub corners
    send(16'h00FF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h0005, 16'h0007, 1'b1);
    send(16'h8000, 16'h0001, 1'b1);
    drain();

    // streaming, alternating mode
    for (int i = 0; i < 8; i++) send(16'(i), 16'd3, 1'(i % 2));
    drain();

    // backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(i), 16'd3, 1'(i % 2));
      end
      begin
        idle(5);
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with three transactions in flight
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h0001, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    idle(6);
    send(16'h0042, 16'h0010, 1'b1);
    drain();

    // randomized traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          idle($urandom_range(0, 2));
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
